// File: rtl/pe_feeder_pkg.sv
// Shared constants, config field layout and FSM state type for the PE feeder.
package pe_feeder_pkg;

    localparam int PE_ADDR_W = 16;
    localparam int PE_DATA_W = 32;
    localparam int PE_CFG_W  = 13;

    localparam int CFG_DW_BIT = 12;
    localparam int CFG_RS_LSB = 10;
    localparam int CFG_RS_W   = 2;
    localparam int CFG_P_LSB  = 7;
    localparam int CFG_P_W    = 2;
    localparam int CFG_F_LSB  = 2;
    localparam int CFG_F_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_FILTER,
        ST_IFMAP,
        ST_IPSUM,
        ST_OPSUM,
        ST_DONE
    } state_t;

    // Config stores sizes minus one; returns the real size (1..4).
    function automatic logic [4:0] size_of(input logic [1:0] m1);
        return {3'b000, m1} + 5'd1;
    endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// GLB read/write ports and PE stream handshakes between the feeder and its neighbours.
interface pe_feeder_if
    import pe_feeder_pkg::*;
#(
    parameter int ADDR_W = PE_ADDR_W,
    parameter int DATA_W = PE_DATA_W,
    parameter int CFG_W  = PE_CFG_W
);
    logic              glb_ren;
    logic [ADDR_W-1:0] glb_raddr;
    logic [DATA_W-1:0] glb_rdata;
    logic              glb_wen;
    logic [ADDR_W-1:0] glb_waddr;
    logic [DATA_W-1:0] glb_wdata;

    logic              PE_en;
    logic [CFG_W-1:0]  i_config;
    logic [DATA_W-1:0] filter;
    logic              filter_valid;
    logic              filter_ready;
    logic [DATA_W-1:0] ifmap;
    logic              ifmap_valid;
    logic              ifmap_ready;
    logic [DATA_W-1:0] ipsum;
    logic              ipsum_valid;
    logic              ipsum_ready;
    logic [DATA_W-1:0] opsum;
    logic              opsum_valid;
    logic              opsum_ready;

    modport master (
        output glb_ren, glb_raddr, glb_wen, glb_waddr, glb_wdata,
        input  glb_rdata,
        output PE_en, i_config,
        output filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid,
        input  filter_ready, ifmap_ready, ipsum_ready,
        input  opsum, opsum_valid,
        output opsum_ready
    );

    modport slave (
        input  glb_ren, glb_raddr, glb_wen, glb_waddr, glb_wdata,
        output glb_rdata,
        input  PE_en, i_config,
        input  filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid,
        output filter_ready, ifmap_ready, ipsum_ready,
        output opsum, opsum_valid,
        input  opsum_ready
    );

endinterface

// File: rtl/pe_feeder_fifo.sv
// Two-entry prefetch FIFO; push and pop may coincide even when full.
module pe_feeder_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rp];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/pe_feeder.sv
// Feeds one pointwise PE from the GLB (config, filter, ifmap, ipsum) and writes its opsums back.
//   state  | meaning
//   IDLE   | waiting for start
//   CFG    | PE_en pulse with config
//   FILTER | stream P*RS filter words
//   IFMAP  | stream RS words (col 0) or 1 word (later cols)
//   IPSUM  | stream P ipsum words of current column
//   OPSUM  | accept P opsums, write each to GLB
//   DONE   | done pulse
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int ADDR_W = PE_ADDR_W,
    parameter int DATA_W = PE_DATA_W,
    parameter int CFG_W  = PE_CFG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CFG_W-1:0]  cfg_in,
    input  logic [ADDR_W-1:0] filter_base,
    input  logic [ADDR_W-1:0] ifmap_base,
    input  logic [ADDR_W-1:0] ipsum_base,
    input  logic [ADDR_W-1:0] opsum_base,
    output logic              busy,
    output logic              done,
    pe_feeder_if.master       bus
);
    state_t            state;
    logic [CFG_W-1:0]  cfg_q;
    logic [CFG_W-1:0]  i_config_q;
    logic              pe_en_q;
    logic [ADDR_W-1:0] ipsum_base_q;
    logic [ADDR_W-1:0] opsum_base_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] ifm_ptr;
    logic [ADDR_W-1:0] col_off;
    logic [4:0]        col;
    logic [4:0]        rd_left;
    logic [4:0]        xfer_left;
    logic [1:0]        op_cnt;
    logic              inflight;

    logic [4:0]        p_words;
    logic [4:0]        rs_words;
    logic [4:0]        filt_words;
    logic [4:0]        f_last;
    logic [1:0]        p_m1;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;

    logic              stream_st;
    logic              chan_ready;
    logic              pop;
    logic              ren;
    logic              last_pop;
    logic              opsum_acc;
    logic [2:0]        occ;

    assign p_m1       = cfg_q[CFG_P_LSB +: CFG_P_W];
    assign p_words    = size_of(p_m1);
    assign rs_words   = size_of(cfg_q[CFG_RS_LSB +: CFG_RS_W]);
    assign filt_words = p_words * rs_words;
    assign f_last     = cfg_q[CFG_F_LSB +: CFG_F_W];

    pe_feeder_fifo #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (bus.glb_rdata),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Occupancy counts the word leaving this cycle so back-to-back ready sustains 1 word/cycle.
    always_comb begin
        stream_st  = (state == ST_FILTER) || (state == ST_IFMAP) || (state == ST_IPSUM);
        chan_ready = 1'b0;
        case (state)
            ST_FILTER: chan_ready = bus.filter_ready;
            ST_IFMAP:  chan_ready = bus.ifmap_ready;
            ST_IPSUM:  chan_ready = bus.ipsum_ready;
            default:   chan_ready = 1'b0;
        endcase
        pop       = stream_st && !fifo_empty && chan_ready;
        occ       = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        ren       = stream_st && (rd_left != 5'd0) && (occ < 3'd2) && (!fifo_full || pop);
        last_pop  = pop && (xfer_left == 5'd1);
        opsum_acc = (state == ST_OPSUM) && bus.opsum_valid;
    end

    assign bus.glb_ren      = ren;
    assign bus.glb_raddr    = !ren ? '0 : ((state == ST_IFMAP) ? ifm_ptr : rd_ptr);
    assign bus.filter       = fifo_head;
    assign bus.ifmap        = fifo_head;
    assign bus.ipsum        = fifo_head;
    assign bus.filter_valid = (state == ST_FILTER) && !fifo_empty;
    assign bus.ifmap_valid  = (state == ST_IFMAP) && !fifo_empty;
    assign bus.ipsum_valid  = (state == ST_IPSUM) && !fifo_empty;
    assign bus.opsum_ready  = (state == ST_OPSUM);
    assign bus.glb_wen      = opsum_acc;
    assign bus.glb_waddr    = opsum_acc ? (opsum_base_q + col_off + ADDR_W'(op_cnt)) : '0;
    assign bus.glb_wdata    = opsum_acc ? bus.opsum : '0;
    assign bus.PE_en        = pe_en_q;
    assign bus.i_config     = i_config_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cfg_q        <= '0;
            i_config_q   <= '0;
            pe_en_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ipsum_base_q <= '0;
            opsum_base_q <= '0;
            rd_ptr       <= '0;
            ifm_ptr      <= '0;
            col_off      <= '0;
            col          <= '0;
            rd_left      <= '0;
            xfer_left    <= '0;
            op_cnt       <= '0;
            inflight     <= 1'b0;
        end else begin
            pe_en_q  <= 1'b0;
            done     <= 1'b0;
            inflight <= ren;
            if (ren) begin
                rd_left <= rd_left - 5'd1;
                if (state == ST_IFMAP) ifm_ptr <= ifm_ptr + ADDR_W'(1);
                else                   rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            if (pop) xfer_left <= xfer_left - 5'd1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_q        <= cfg_in;
                        i_config_q   <= cfg_in & ~(CFG_W'(1) << CFG_DW_BIT);
                        pe_en_q      <= 1'b1;
                        busy         <= 1'b1;
                        ipsum_base_q <= ipsum_base;
                        opsum_base_q <= opsum_base;
                        rd_ptr       <= filter_base;
                        ifm_ptr      <= ifmap_base;
                        col          <= '0;
                        col_off      <= '0;
                        state        <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    rd_left   <= filt_words;
                    xfer_left <= filt_words;
                    state     <= ST_FILTER;
                end
                ST_FILTER: begin
                    if (last_pop) begin
                        rd_left   <= rs_words;
                        xfer_left <= rs_words;
                        state     <= ST_IFMAP;
                    end
                end
                ST_IFMAP: begin
                    if (last_pop) begin
                        rd_left   <= p_words;
                        xfer_left <= p_words;
                        rd_ptr    <= ipsum_base_q + col_off;
                        state     <= ST_IPSUM;
                    end
                end
                ST_IPSUM: begin
                    if (last_pop) begin
                        op_cnt <= '0;
                        state  <= ST_OPSUM;
                    end
                end
                ST_OPSUM: begin
                    if (opsum_acc) begin
                        op_cnt <= op_cnt + 2'd1;
                        if (op_cnt == p_m1) begin
                            if (col == f_last) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                // Later columns slide the ifmap window by one word.
                                col       <= col + 5'd1;
                                col_off   <= col_off + ADDR_W'(p_words);
                                rd_left   <= 5'd1;
                                xfer_left <= 5'd1;
                                state     <= ST_IFMAP;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Randomised bench for pe_feeder: GLB and PE models plus an expected transfer trace per job.
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] cfg_in;
    logic [15:0] filter_base, ifmap_base, ipsum_base, opsum_base;
    logic        busy, done;

    pe_feeder_if bus ();

    pe_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_in      (cfg_in),
        .filter_base (filter_base),
        .ifmap_base  (ifmap_base),
        .ipsum_base  (ipsum_base),
        .opsum_base  (opsum_base),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          n_vec = 0, n_err = 0;
    int          job_gen = 0, seen_gen = 0, ev_idx = 0;
    int          done_cnt = 0, pe_cnt = 0, viol = 0, op_n = 0;
    int          cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    int          d0, p0, v0;
    bit          rdy_rand = 0, op_rand = 0, op_acc = 0;
    logic [12:0] exp_cfg = '0;
    logic        prev_hold[3];
    logic [31:0] prev_d[3];
    logic        vv[3], rr[3];
    logic [31:0] dd[3];

    function automatic logic [31:0] gfun(input logic [15:0] a);
        return {~a, a} ^ 32'h3C3C_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take(input int kind, input logic [15:0] a, input logic [31:0] d);
        ev_t e;
        if (ev_idx >= exp_q.size()) begin
            chk("extra_xfer", ev_idx, exp_q.size());
        end else begin
            e = exp_q[ev_idx];
            ev_idx++;
            chk("xfer_kind", kind, e.kind);
            chk("xfer_data", d, e.d);
            if (kind == 3) chk("opsum_waddr", a, e.a);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.glb_ren) bus.glb_rdata <= gfun(bus.glb_raddr);
    end

    // PE-side drivers: readies and opsum source (valid held until accepted)
    initial begin
        bus.filter_ready = 0; bus.ifmap_ready = 0; bus.ipsum_ready = 0;
        bus.opsum_valid = 0; bus.opsum = '0;
        forever begin
            @(posedge clk); #1;
            bus.filter_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
            bus.ifmap_ready  = rdy_rand ? 1'($urandom % 2) : 1'b1;
            bus.ipsum_ready  = rdy_rand ? 1'($urandom % 2) : 1'b1;
            if (!(bus.opsum_valid && !op_acc))
                bus.opsum_valid = op_rand ? 1'($urandom % 2) : 1'b1;
            bus.opsum = 32'hC0DE_0000 + 32'(op_n);
        end
    end

    always @(negedge clk) begin
        op_acc = 0;
        if (job_gen != seen_gen) begin
            seen_gen = job_gen; ev_idx = 0; op_n = 0;
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) prev_hold[i] = 0;
        end else begin
            vv[0] = bus.filter_valid; rr[0] = bus.filter_ready; dd[0] = bus.filter;
            vv[1] = bus.ifmap_valid;  rr[1] = bus.ifmap_ready;  dd[1] = bus.ifmap;
            vv[2] = bus.ipsum_valid;  rr[2] = bus.ipsum_ready;  dd[2] = bus.ipsum;
            if (int'(vv[0]) + int'(vv[1]) + int'(vv[2]) > 1) viol++;
            for (int i = 0; i < 3; i++) begin
                if (prev_hold[i]) begin
                    chk("stall_valid_held", vv[i], 1'b1);
                    chk("stall_data_stable", dd[i], prev_d[i]);
                end
                if (vv[i] && rr[i]) take(i, 16'h0, dd[i]);
                prev_hold[i] = vv[i] && !rr[i];
                prev_d[i]    = dd[i];
            end
            if (bus.opsum_valid && bus.opsum_ready) begin
                op_acc = 1;
                chk("wen_on_opsum", bus.glb_wen, 1'b1);
                op_n++;
            end
            if (bus.glb_wen) begin
                take(3, bus.glb_waddr, bus.glb_wdata);
                last_wr_cyc = cyc;
            end
            if (bus.PE_en) begin
                pe_cnt++;
                chk("i_config", bus.i_config, exp_cfg & 13'h0FFF);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_job(input int p, input int rs, input int f, input int q, input int dw,
                             input logic [15:0] fb, input logic [15:0] ib,
                             input logic [15:0] pb, input logic [15:0] ob, input bit stall);
        logic [15:0] ifp;
        exp_q.delete();
        for (int i = 0; i < p * rs; i++)
            exp_q.push_back('{0, 16'(fb + i), gfun(16'(fb + i))});
        ifp = ib;
        for (int c = 0; c <= f; c++) begin
            for (int j = 0; j < ((c == 0) ? rs : 1); j++) begin
                exp_q.push_back('{1, ifp, gfun(ifp)});
                ifp = ifp + 16'd1;
            end
            for (int k = 0; k < p; k++)
                exp_q.push_back('{2, 16'(pb + c * p + k), gfun(16'(pb + c * p + k))});
            for (int k = 0; k < p; k++)
                exp_q.push_back('{3, 16'(ob + c * p + k), 32'hC0DE_0000 + 32'(c * p + k)});
        end
        exp_cfg = {1'(dw), 2'(rs - 1), 1'b0, 2'(p - 1), 5'(f), 2'(q - 1)};
        rdy_rand = stall; op_rand = stall;
        d0 = done_cnt; p0 = pe_cnt; v0 = viol;
        job_gen++;
        @(posedge clk); #1;
        start = 1; cfg_in = exp_cfg;
        filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_job(input bit poke);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = poke && (i == 10);
            if (start) begin
                cfg_in = 13'h1FFF; filter_base = 16'h7777;
            end
            if (done_cnt != d0) break;
        end
        start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("pe_en_count", pe_cnt - p0, 1);
        chk("trace_consumed", ev_idx, exp_q.size());
        chk("one_valid_at_a_time", viol - v0, 0);
        chk("busy_after_done", busy, 1'b0);
        chk("done_latency", done_cyc - last_wr_cyc, 1);
    endtask

    task automatic run_job(input int p, input int rs, input int f, input int q, input int dw,
                           input logic [15:0] fb, input logic [15:0] ib,
                           input logic [15:0] pb, input logic [15:0] ob,
                           input bit stall, input bit poke);
        start_job(p, rs, f, q, dw, fb, ib, pb, ob, stall);
        finish_job(poke);
    endtask

    initial begin
        bit found;
        rst = 1; start = 0; cfg_in = '0;
        filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, done, bus.glb_ren, bus.glb_wen, bus.filter_valid,
                           bus.ifmap_valid, bus.ipsum_valid, bus.opsum_ready, bus.PE_en}, 0);
        chk("reset_cfg_addr", {bus.i_config, bus.glb_raddr, bus.glb_waddr}, 0);
        @(posedge clk); #1 rst = 0;

        run_job(1, 1, 0, 1, 0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0);
        run_job(4, 3, 2, 2, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0);
        run_job(4, 3, 2, 2, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1, 0);
        run_job(2, 2, 1, 1, 0, 16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFE, 1, 0);

        // abort in IPSUM
        start_job(4, 3, 2, 2, 0, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 0);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (bus.ipsum_valid) found = 1;
        end
        chk("reached_ipsum", found, 1'b1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs", {bus.filter_valid, bus.ifmap_valid, bus.ipsum_valid,
                              busy, done, bus.glb_ren, bus.glb_wen}, 0);
        @(posedge clk); #1 rst = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_job(3, 2, 3, 4, 1, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 1, 0);

        run_job(4, 3, 2, 2, 0, 16'h1100, 16'h2200, 16'h3300, 16'h4400, 0, 1);

        for (int t = 0; t < 5; t++)
            run_job($urandom_range(4, 1), $urandom_range(4, 1), $urandom_range(4, 0),
                    $urandom_range(4, 1), $urandom_range(1, 0),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom % 2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
